sw_port_pkt: RTL
================

Name: sw_port_pkt

Overview:
Next-generation switch output port. Replaces the plain word FIFO with a store-and-forward packet buffer.
- Accepts only packets whose destination address matches port_addr.
- Presents a packet to the reader only once it is completely stored.
- If a packet overflows the buffer, rolls it back atomically and counts it as dropped.
- Sits between the switch fabric (sw_en/port_data) and the output consumer (port_rd/port_out).

Parameters:
FIFO_SIZE, 64, buffer depth in words; power of 2, >=4
W_WIDTH, 8, word width
CNT_W, 8, width of the statistics counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sw_en  in  1  high for the contiguous cycles of one incoming packet; low >=1 cycle between packets
port_data  in  W_WIDTH  incoming word; first word of a packet is DA
port_addr  in  W_WIDTH  this port's address; static while sw_en=1
rd_out  out  1  buffer not full (combinational from pointers)
port_rd  in  1  pop one word; honoured only when port_rdy=1
port_out  out  W_WIDTH  popped word, registered
port_eop  out  1  registered; marks port_out as last word of its packet
port_rdy  out  1  >=1 complete packet stored
pkt_cnt  out  CNT_W  accepted, committed packets; saturating
drop_cnt  out  CNT_W  matched packets discarded on overflow; saturating

Behaviour:
- Reset (async, rst_n=0):
  - pointers, state and counters -> 0/IDLE
  - port_out=0, port_eop=0, port_rdy=0, rd_out=1
  - reset mid-packet discards all content
- Storage:
  - mem[FIFO_SIZE] of W_WIDTH, plus eop[FIFO_SIZE] 1-bit flags
  - pointers are log2(FIFO_SIZE)+1 bits: wr_ptr (speculative), cm_ptr (committed), rd_ptr
  - used = wr_ptr-rd_ptr; full when used==FIFO_SIZE
  - pointer index wraps modulo FIFO_SIZE
- Write FSM states: IDLE, RECV, SKIP, DROP.
  - IDLE, sw_en=1, port_data==port_addr, !full: write DA, eop=0, wr_ptr++ -> RECV.
  - IDLE, sw_en=1, DA mismatch: no write -> SKIP. Not counted.
  - RECV, sw_en=1, !full: write word, wr_ptr++.
  - RECV, sw_en=1, full: wr_ptr<=cm_ptr (rollback), drop_cnt++ -> DROP. The current word is not written.
  - RECV, sw_en=0: set eop[wr_ptr-1]=1, cm_ptr<=wr_ptr, pkt_avail++, pkt_cnt++ -> IDLE.
  - SKIP/DROP: stay while sw_en=1; sw_en=0 -> IDLE.
  - A packet longer than FIFO_SIZE words is always dropped.
- Read side:
  - pkt_avail counts complete packets not yet fully popped; port_rdy = (pkt_avail!=0).
  - port_rd=1 and port_rdy=1: port_out<=mem[rd_ptr], port_eop<=eop[rd_ptr], rd_ptr++. Data is valid the cycle after port_rd.
  - Popping a word with eop=1 clears that flag and decrements pkt_avail.
  - port_rd with port_rdy=0 is ignored; port_out and port_eop hold their values.
  - The reader never reads beyond cm_ptr.
  - Consumers read a packet to its eop before relying on the next port_rdy.
- Simultaneous events:
  - Commit and eop-pop in the same cycle: pkt_avail unchanged.
  - Write and read in the same cycle: both proceed. Full is evaluated before the same-cycle pop, so freed space is usable from the next cycle.
  - Rollback and pop in the same cycle: both proceed; rd_ptr is never beyond cm_ptr.
- Counters hold at 2^CNT_W-1.

Optional Feature:
SW_PORT_BCAST_EN:
- Defined: in IDLE, a DA of all ones (broadcast) is accepted like a matching DA, stored, counted and dropped on overflow identically.
- Undefined: an all-ones DA is accepted only if port_addr is all ones.

Test Plan:
- port_addr=8'h05; packet 05,A1,A2,A3 (sw_en 4 cycles) -> port_rdy=1 the cycle after sw_en falls; pkt_cnt=1. Four port_rd pulses -> port_out 05,A1,A2,A3; port_eop=1 on A3 only; port_rdy=0 after.
- port_addr=8'h05; packet 07,B1,B2 -> nothing stored, port_rdy=0, pkt_cnt=0, drop_cnt=0.
- FIFO_SIZE=64, no reads; packet of 70 words with DA=05 -> drop_cnt=1, port_rdy=0, rd_out=1. A following 3-word packet is accepted; pkt_cnt=1.
- Two back-to-back 2-word packets, then reader pops concurrently with the second commit -> pkt_avail tracked correctly; port_rdy stays 1 until the second eop is popped.
- rst_n=0 asserted mid-packet -> all outputs return to reset values immediately. A subsequent packet is received cleanly.
- SW_PORT_BCAST_EN defined, port_addr=05, DA=FF, 3 words -> stored, pkt_cnt=1. Undefined -> skipped.

Source files
------------

// File: rtl/sw_port_pkt.sv
// rtl/sw_port_pkt.sv - store-and-forward switch output port with atomic overflow rollback
// Optional broadcast DA acceptance: define SW_PORT_BCAST_EN.
module sw_port_pkt #(
  parameter int FIFO_SIZE = 64,
  parameter int W_WIDTH   = 8,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_en,
  input  logic [W_WIDTH-1:0] port_data,
  input  logic [W_WIDTH-1:0] port_addr,
  output logic               rd_out,
  input  logic               port_rd,
  output logic [W_WIDTH-1:0] port_out,
  output logic               port_eop,
  output logic               port_rdy,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int AW = $clog2(FIFO_SIZE);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, RECV, SKIP, DROP} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, cm_ptr_q, rd_ptr_q, pkt_avail_q;
  logic [W_WIDTH-1:0] port_out_q;
  logic               port_eop_q;
  logic [CNT_W-1:0]   pkt_cnt_q, drop_cnt_q;
  logic [W_WIDTH-1:0] mem_q [FIFO_SIZE];
  logic               eop_q [FIFO_SIZE];

  logic [PW-1:0] used, wr_last;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          full, da_match, wr_en, commit, rollback, drop_inc, rd_fire, pop_eop;

  assign used     = wr_ptr_q - rd_ptr_q;
  assign full     = (used == PW'(FIFO_SIZE));
  assign wr_last  = wr_ptr_q - PW'(1);
  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign rd_idx   = rd_ptr_q[AW-1:0];
  assign rd_out   = !full;
  assign port_rdy = (pkt_avail_q != '0);
  assign port_out = port_out_q;
  assign port_eop = port_eop_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

`ifdef SW_PORT_BCAST_EN
  assign da_match = (port_data == port_addr) || (&port_data);
`else
  assign da_match = (port_data == port_addr);
`endif

  // The committed pointer bounds the reader even if a consumer pops past an eop early.
  assign rd_fire = port_rd && port_rdy && (rd_ptr_q != cm_ptr_q);
  assign pop_eop = rd_fire && eop_q[rd_idx];

  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    commit   = 1'b0;
    rollback = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      IDLE: if (sw_en) begin
        if (!da_match) begin
          state_d = SKIP;
        end else if (!full) begin
          wr_en   = 1'b1;
          state_d = RECV;
        end else begin
          drop_inc = 1'b1;
          state_d  = DROP;
        end
      end
      RECV: if (sw_en) begin
        if (!full) begin
          wr_en = 1'b1;
        end else begin
          rollback = 1'b1;
          drop_inc = 1'b1;
          state_d  = DROP;
        end
      end else begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      SKIP, DROP: if (!sw_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= port_data;
      eop_q[wr_idx] <= 1'b0;
    end
    if (commit) eop_q[wr_last[AW-1:0]] <= 1'b1;
    if (pop_eop) eop_q[rd_idx] <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_avail_q <= '0;
      port_out_q  <= '0;
      port_eop_q  <= 1'b0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en)         wr_ptr_q <= wr_ptr_q + PW'(1);
      else if (rollback) wr_ptr_q <= cm_ptr_q;
      if (commit) cm_ptr_q <= wr_ptr_q;
      if (rd_fire) begin
        rd_ptr_q   <= rd_ptr_q + PW'(1);
        port_out_q <= mem_q[rd_idx];
        port_eop_q <= eop_q[rd_idx];
      end
      if (commit && !pop_eop)      pkt_avail_q <= pkt_avail_q + PW'(1);
      else if (!commit && pop_eop) pkt_avail_q <= pkt_avail_q - PW'(1);
      if (commit && (pkt_cnt_q != '1))    pkt_cnt_q  <= pkt_cnt_q + CNT_W'(1);
      if (drop_inc && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

endmodule
